// File: rtl/mod_counter_checker.sv
// mod_counter_checker: locks onto a mod-2^WIDTH incrementing bus and flags
// deviations. Optional MOD_COUNTER_CHECKER_STICKY_EN makes ERR sticky.
//
// Ports:
//   CLK      rising-edge clock
//   RST      async active-low reset
//   EN       sample enable; D is sampled when EN=1
//   D        observed counter value
//   LOCKED   sequence currently tracked
//   ERR      locked mismatch (pulse, or sticky with the macro)
//   EXP      value expected at the next sample
//   ERR_CNT  locked mismatches, saturating at 255
//   WRAP_CNT locked wraps to 0, mod 256
module mod_counter_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic             LOCKED,
  output logic             ERR,
  output logic [WIDTH-1:0] EXP,
  output logic [7:0]       ERR_CNT,
  output logic [7:0]       WRAP_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_N = 5'(LOCK_LEN);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  state_t           state_n;
  logic [3:0]       mc;
  logic [3:0]       mc_n;
  logic [4:0]       mc_inc;
  logic [WIDTH-1:0] exp_n;
  logic [WIDTH-1:0] d_inc;
  logic             hit;
  logic             locked_n;
  logic             err_n;
  logic [7:0]       err_cnt_n;
  logic [7:0]       wrap_cnt_n;

  assign d_inc  = D + ONE;
  assign hit    = (D == EXP);
  assign mc_inc = {1'b0, mc} + 5'd1;

  always_comb begin
    state_n    = state;
    mc_n       = mc;
    exp_n      = EXP;
    locked_n   = LOCKED;
    err_cnt_n  = ERR_CNT;
    wrap_cnt_n = WRAP_CNT;
`ifdef MOD_COUNTER_CHECKER_STICKY_EN
    err_n      = ERR;
`else
    err_n      = 1'b0;
`endif
    if (EN) begin
      // Every sample resyncs EXP to D+1; only the bookkeeping differs.
      exp_n = d_inc;
      unique case (state)
        IDLE: begin
          mc_n    = 4'd0;
          state_n = HUNT;
        end
        HUNT: begin
          if (hit) begin
            mc_n = mc_inc[3:0];
            if (mc_inc == LOCK_N) begin
              state_n  = LOCK;
              locked_n = 1'b1;
            end
          end else begin
            mc_n = 4'd0;
          end
        end
        LOCK: begin
          if (hit) begin
            if (D == ZERO) begin
              wrap_cnt_n = WRAP_CNT + 8'd1;
            end
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            state_n  = HUNT;
            mc_n     = 4'd0;
            if (ERR_CNT != 8'hff) begin
              err_cnt_n = ERR_CNT + 8'd1;
            end
          end
        end
        default: begin
          state_n  = IDLE;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      mc       <= 4'd0;
      EXP      <= '0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      ERR_CNT  <= 8'd0;
      WRAP_CNT <= 8'd0;
    end else begin
      state    <= state_n;
      mc       <= mc_n;
      EXP      <= exp_n;
      LOCKED   <= locked_n;
      ERR      <= err_n;
      ERR_CNT  <= err_cnt_n;
      WRAP_CNT <= wrap_cnt_n;
    end
  end

endmodule
